// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decode control and datapath fields for the execute stage,
// inserts a bubble on a load-use hazard or a MEM-stage flush, and keeps
// a saturating count of bubbles for the debug unit.
module id_ex_register #(
    parameter int NB_DATA       = 32,
    parameter int NB_REG        = 5,
    parameter int NB_CTRL_EX    = 6,
    parameter int NB_CTRL_M     = 9,
    parameter int NB_CTRL_WB    = 2,
    parameter int NB_BUBBLE_CNT = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic                     i_flush,
    input  logic [NB_CTRL_WB-1:0]    i_ctrl_wb_bus,
    input  logic [NB_CTRL_M-1:0]     i_ctrl_mem_bus,
    input  logic [NB_CTRL_EX-1:0]    i_ctrl_exc_bus,
    input  logic [NB_DATA-1:0]       i_pc_plus4,
    input  logic [NB_DATA-1:0]       i_read_data_1,
    input  logic [NB_DATA-1:0]       i_read_data_2,
    input  logic [NB_DATA-1:0]       i_sign_ext,
    input  logic [NB_REG-1:0]        i_rs,
    input  logic [NB_REG-1:0]        i_rt,
    input  logic [NB_REG-1:0]        i_rd,
    input  logic [NB_REG-1:0]        i_shamt,
    output logic [NB_CTRL_WB-1:0]    o_ctrl_wb_bus,
    output logic [NB_CTRL_M-1:0]     o_ctrl_mem_bus,
    output logic [NB_CTRL_EX-1:0]    o_ctrl_exc_bus,
    output logic [NB_DATA-1:0]       o_pc_plus4,
    output logic [NB_DATA-1:0]       o_read_data_1,
    output logic [NB_DATA-1:0]       o_read_data_2,
    output logic [NB_DATA-1:0]       o_sign_ext,
    output logic [NB_REG-1:0]        o_rs,
    output logic [NB_REG-1:0]        o_rt,
    output logic [NB_REG-1:0]        o_rd,
    output logic [NB_REG-1:0]        o_shamt,
    output logic                     o_stall,
    output logic [NB_BUBBLE_CNT-1:0] o_bubble_count
);

    logic [NB_CTRL_WB-1:0]    ctrl_wb_p1;
    logic [NB_CTRL_M-1:0]     ctrl_mem_p1;
    logic [NB_CTRL_EX-1:0]    ctrl_exc_p1;
    logic [NB_DATA-1:0]       pc_plus4_p1;
    logic [NB_DATA-1:0]       read_data_1_p1;
    logic [NB_DATA-1:0]       read_data_2_p1;
    logic [NB_DATA-1:0]       sign_ext_p1;
    logic [NB_REG-1:0]        rs_p1;
    logic [NB_REG-1:0]        rt_p1;
    logic [NB_REG-1:0]        rd_p1;
    logic [NB_REG-1:0]        shamt_p1;
    logic [NB_BUBBLE_CNT-1:0] bubble_cnt;
    logic                     hazard;
    logic                     bubble;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [NB_BUBBLE_CNT-1:0] sat_inc(input logic [NB_BUBBLE_CNT-1:0] val);
        if (&val) begin
            sat_inc = val;
        end else begin
            sat_inc = val + 1'b1;
        end
    endfunction

    // Load in EX (MemtoReg and MemRead both set; MemtoReg excludes BEQ)
    // whose target is read by the instruction in ID. A flush overrides it.
    always_comb begin
        hazard = 1'b0;
        bubble = 1'b0;
        if (ctrl_wb_p1[0] && ctrl_mem_p1[1] && (rt_p1 != '0) &&
            ((rt_p1 == i_rs) || (rt_p1 == i_rt))) begin
            hazard = !i_flush;
        end
        bubble = i_flush || hazard;
    end

    // ---- ID -> EX stage boundary ----
    // Flush clears everything, a stall zeroes only the control buses,
    // otherwise every decode field is captured.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ctrl_wb_p1     <= '0;
            ctrl_mem_p1    <= '0;
            ctrl_exc_p1    <= '0;
            pc_plus4_p1    <= '0;
            read_data_1_p1 <= '0;
            read_data_2_p1 <= '0;
            sign_ext_p1    <= '0;
            rs_p1          <= '0;
            rt_p1          <= '0;
            rd_p1          <= '0;
            shamt_p1       <= '0;
            bubble_cnt     <= '0;
        end else if (i_enable) begin
            if (i_flush) begin
                ctrl_wb_p1     <= '0;
                ctrl_mem_p1    <= '0;
                ctrl_exc_p1    <= '0;
                pc_plus4_p1    <= '0;
                read_data_1_p1 <= '0;
                read_data_2_p1 <= '0;
                sign_ext_p1    <= '0;
                rs_p1          <= '0;
                rt_p1          <= '0;
                rd_p1          <= '0;
                shamt_p1       <= '0;
            end else begin
                ctrl_wb_p1     <= hazard ? '0 : i_ctrl_wb_bus;
                ctrl_mem_p1    <= hazard ? '0 : i_ctrl_mem_bus;
                ctrl_exc_p1    <= hazard ? '0 : i_ctrl_exc_bus;
                pc_plus4_p1    <= i_pc_plus4;
                read_data_1_p1 <= i_read_data_1;
                read_data_2_p1 <= i_read_data_2;
                sign_ext_p1    <= i_sign_ext;
                rs_p1          <= i_rs;
                rt_p1          <= i_rt;
                rd_p1          <= i_rd;
                shamt_p1       <= i_shamt;
            end
            if (bubble) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
        end
    end

    assign o_ctrl_wb_bus  = ctrl_wb_p1;
    assign o_ctrl_mem_bus = ctrl_mem_p1;
    assign o_ctrl_exc_bus = ctrl_exc_p1;
    assign o_pc_plus4     = pc_plus4_p1;
    assign o_read_data_1  = read_data_1_p1;
    assign o_read_data_2  = read_data_2_p1;
    assign o_sign_ext     = sign_ext_p1;
    assign o_rs           = rs_p1;
    assign o_rt           = rt_p1;
    assign o_rd           = rd_p1;
    assign o_shamt        = shamt_p1;
    assign o_stall        = hazard;
    assign o_bubble_count = bubble_cnt;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed testbench for id_ex_register (bubble counter built 4 bits wide).
module tb_id_ex_register;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_CNT  = 4;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_enable;
    logic                i_flush;
    logic [1:0]          i_ctrl_wb_bus;
    logic [8:0]          i_ctrl_mem_bus;
    logic [5:0]          i_ctrl_exc_bus;
    logic [NB_DATA-1:0]  i_pc_plus4, i_read_data_1, i_read_data_2, i_sign_ext;
    logic [NB_REG-1:0]   i_rs, i_rt, i_rd, i_shamt;
    logic [1:0]          o_ctrl_wb_bus;
    logic [8:0]          o_ctrl_mem_bus;
    logic [5:0]          o_ctrl_exc_bus;
    logic [NB_DATA-1:0]  o_pc_plus4, o_read_data_1, o_read_data_2, o_sign_ext;
    logic [NB_REG-1:0]   o_rs, o_rt, o_rd, o_shamt;
    logic                o_stall;
    logic [NB_CNT-1:0]   o_bubble_count;

    int checks = 0;
    int errors = 0;

    id_ex_register #(
        .NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_CTRL_EX(6), .NB_CTRL_M(9),
        .NB_CTRL_WB(2), .NB_BUBBLE_CNT(NB_CNT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_flush(i_flush),
        .i_ctrl_wb_bus(i_ctrl_wb_bus), .i_ctrl_mem_bus(i_ctrl_mem_bus),
        .i_ctrl_exc_bus(i_ctrl_exc_bus), .i_pc_plus4(i_pc_plus4),
        .i_read_data_1(i_read_data_1), .i_read_data_2(i_read_data_2),
        .i_sign_ext(i_sign_ext), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
        .i_shamt(i_shamt), .o_ctrl_wb_bus(o_ctrl_wb_bus),
        .o_ctrl_mem_bus(o_ctrl_mem_bus), .o_ctrl_exc_bus(o_ctrl_exc_bus),
        .o_pc_plus4(o_pc_plus4), .o_read_data_1(o_read_data_1),
        .o_read_data_2(o_read_data_2), .o_sign_ext(o_sign_ext), .o_rs(o_rs),
        .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt), .o_stall(o_stall),
        .o_bubble_count(o_bubble_count)
    );

    always #5 i_clk = ~i_clk;

    // Set the decode-side inputs for one instruction.
    task automatic drive(input logic [1:0] wb, input logic [8:0] mem, input logic [5:0] exc,
                         input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        i_ctrl_wb_bus  = wb;
        i_ctrl_mem_bus = mem;
        i_ctrl_exc_bus = exc;
        i_pc_plus4     = pc;
        i_read_data_1  = pc + 32'h11;
        i_read_data_2  = pc + 32'h22;
        i_sign_ext     = pc + 32'h33;
        i_rs           = rs;
        i_rt           = rt;
        i_rd           = rd;
        i_shamt        = 5'd3;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b0; i_enable = 1'b1; i_flush = 1'b0;
        drive(2'b11, 9'h1FD, 6'h3F, 32'hDEAD_BEE0, 5'd7, 5'd9, 5'd4);
        step();
        @(negedge i_clk);
        i_rst = 1'b1;
        step();
        checks++;
        if (o_pc_plus4 !== 32'hDEAD_BEE0) begin
            errors++; $display("FAIL pre_reset_capture got %h exp %h", o_pc_plus4, 32'hDEAD_BEE0);
        end
        #2 i_rst = 1'b0;
        #1;
        checks++;
        if ({o_ctrl_wb_bus, o_ctrl_mem_bus, o_ctrl_exc_bus, o_pc_plus4, o_read_data_1,
             o_read_data_2, o_sign_ext, o_rs, o_rt, o_rd, o_shamt} !== '0 ||
            o_bubble_count !== '0 || o_stall !== 1'b0) begin
            errors++; $display("FAIL async_reset got pc=%h wb=%b cnt=%0d stall=%b exp all zero",
                               o_pc_plus4, o_ctrl_wb_bus, o_bubble_count, o_stall);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        drive(2'b10, 9'h000, 6'b100110, 32'h104, 5'd1, 5'd2, 5'd3);
        step();
        checks++;
        if (o_ctrl_exc_bus !== 6'b100110 || o_pc_plus4 !== 32'h104 || o_ctrl_wb_bus !== 2'b10) begin
            errors++; $display("FAIL first_capture got exc=%b pc=%h wb=%b exp 100110 104 10",
                               o_ctrl_exc_bus, o_pc_plus4, o_ctrl_wb_bus);
        end
    endtask

    task automatic test_load_use();
        drive(2'b11, 9'b000000010, 6'b100000, 32'h108, 5'd1, 5'd5, 5'd0);
        step();
        drive(2'b10, 9'h000, 6'b100110, 32'h200, 5'd5, 5'd6, 5'd7);
        #1;
        checks++;
        if (o_stall !== 1'b1) begin
            errors++; $display("FAIL load_use_stall got %b exp 1", o_stall);
        end
        step();
        checks++;
        if (o_ctrl_wb_bus !== 2'b00 || o_ctrl_mem_bus !== 9'h000 || o_ctrl_exc_bus !== 6'h00 ||
            o_bubble_count !== 4'd1 || o_stall !== 1'b0) begin
            errors++; $display("FAIL bubble got wb=%b mem=%b exc=%b cnt=%0d stall=%b exp 0 0 0 1 0",
                               o_ctrl_wb_bus, o_ctrl_mem_bus, o_ctrl_exc_bus, o_bubble_count, o_stall);
        end
        step();
        checks++;
        if (o_pc_plus4 !== 32'h200 || o_ctrl_exc_bus !== 6'b100110 || o_ctrl_wb_bus !== 2'b10 ||
            o_rs !== 5'd5 || o_bubble_count !== 4'd1) begin
            errors++; $display("FAIL held_capture got pc=%h exc=%b wb=%b rs=%0d cnt=%0d exp 200 100110 10 5 1",
                               o_pc_plus4, o_ctrl_exc_bus, o_ctrl_wb_bus, o_rs, o_bubble_count);
        end
    endtask

    task automatic test_no_false_hazard();
        drive(2'b00, 9'b000000010, 6'b000010, 32'h20C, 5'd1, 5'd5, 5'd0);
        step();
        drive(2'b10, 9'h000, 6'b100110, 32'h210, 5'd5, 5'd5, 5'd8);
        #1;
        checks++;
        if (o_stall !== 1'b0) begin
            errors++; $display("FAIL beq_no_stall got %b exp 0", o_stall);
        end
        drive(2'b11, 9'b000000010, 6'b100000, 32'h214, 5'd2, 5'd0, 5'd0);
        step();
        drive(2'b10, 9'h000, 6'b100110, 32'h218, 5'd0, 5'd0, 5'd8);
        #1;
        checks++;
        if (o_stall !== 1'b0) begin
            errors++; $display("FAIL rt_zero_no_stall got %b exp 0", o_stall);
        end
    endtask

    task automatic test_flush_vs_stall();
        drive(2'b11, 9'b000000010, 6'b100000, 32'h21C, 5'd1, 5'd5, 5'd0);
        step();
        drive(2'b10, 9'h000, 6'b100110, 32'h220, 5'd3, 5'd5, 5'd9);
        #1;
        checks++;
        if (o_stall !== 1'b1) begin
            errors++; $display("FAIL rt_match_stall got %b exp 1", o_stall);
        end
        i_flush = 1'b1;
        #1;
        checks++;
        if (o_stall !== 1'b0) begin
            errors++; $display("FAIL flush_masks_stall got %b exp 0", o_stall);
        end
        step();
        i_flush = 1'b0;
        checks++;
        if ({o_ctrl_wb_bus, o_ctrl_mem_bus, o_ctrl_exc_bus, o_pc_plus4, o_read_data_1,
             o_read_data_2, o_sign_ext, o_rs, o_rt, o_rd, o_shamt} !== '0 ||
            o_bubble_count !== 4'd2) begin
            errors++; $display("FAIL flush_clear got pc=%h rt=%0d cnt=%0d exp 0 0 2",
                               o_pc_plus4, o_rt, o_bubble_count);
        end
    endtask

    task automatic test_enable();
        drive(2'b10, 9'h000, 6'b100110, 32'h300, 5'd1, 5'd2, 5'd3);
        step();
        i_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 9'h0F0, 6'b010101, 32'h310 + 32'(k), 5'd4, 5'd5, 5'd6);
            i_flush = (k == 1);
            step();
            checks++;
            if (o_pc_plus4 !== 32'h300 || o_ctrl_wb_bus !== 2'b10 || o_bubble_count !== 4'd2) begin
                errors++; $display("FAIL enable_hold[%0d] got pc=%h wb=%b cnt=%0d exp 300 10 2",
                                   k, o_pc_plus4, o_ctrl_wb_bus, o_bubble_count);
            end
        end
        i_flush = 1'b0;
        i_enable = 1'b1;
        drive(2'b10, 9'h004, 6'b100111, 32'h400, 5'd7, 5'd8, 5'd9);
        step();
        checks++;
        if (o_pc_plus4 !== 32'h400 || o_ctrl_exc_bus !== 6'b100111 || o_rd !== 5'd9) begin
            errors++; $display("FAIL enable_resume got pc=%h exc=%b rd=%0d exp 400 100111 9",
                               o_pc_plus4, o_ctrl_exc_bus, o_rd);
        end
    endtask

    task automatic test_saturation();
        i_flush = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 12) begin
                checks++;
                if (o_bubble_count !== 4'd14) begin
                    errors++; $display("FAIL sat_ramp got %0d exp 14", o_bubble_count);
                end
            end
        end
        checks++;
        if (o_bubble_count !== 4'd15) begin
            errors++; $display("FAIL sat_peak got %0d exp 15", o_bubble_count);
        end
        step();
        checks++;
        if (o_bubble_count !== 4'd15) begin
            errors++; $display("FAIL sat_hold got %0d exp 15", o_bubble_count);
        end
        i_flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_flush_vs_stall();
        test_enable();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
